// File: rtl/vending_pkg.sv
// vending_pkg: coin encodings, values and FSM state type shared by the change dispenser
package vending_pkg;
    typedef enum logic [1:0] {NICKEL = 2'd0, DIME = 2'd1, QUARTER = 2'd2} coin_t;
    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_EJECT, S_DONE} state_t;
    localparam int VAL_N = 5;
    localparam int VAL_D = 10;
    localparam int VAL_Q = 25;
    localparam logic [2:0] REQ_N = 3'b001;
    localparam logic [2:0] REQ_D = 3'b010;
    localparam logic [2:0] REQ_Q = 3'b100;
    function automatic int coin_value(coin_t c);
        return c == QUARTER ? VAL_Q : c == DIME ? VAL_D : VAL_N;
    endfunction
    function automatic logic [2:0] coin_onehot(coin_t c);
        return c == QUARTER ? REQ_Q : c == DIME ? REQ_D : REQ_N;
    endfunction
endpackage

// File: rtl/coin_select.sv
// coin_select: greedy highest-value pick among coins that fit rem, are stocked and not jammed
module coin_select
    import vending_pkg::*;
#(
    parameter int AMT_W = 9,
    parameter int CNT_W = 8
) (
    input  logic [AMT_W-1:0] rem,
    input  logic [CNT_W-1:0] cnt_q,
    input  logic [CNT_W-1:0] cnt_d,
    input  logic [CNT_W-1:0] cnt_n,
    input  logic [2:0]       jam,
    output logic             sel_valid,
    output coin_t            sel_coin
);
    logic q_ok, d_ok, n_ok;

    always_comb begin
        q_ok      = rem >= AMT_W'(VAL_Q) && cnt_q != '0 && !jam[2];
        d_ok      = rem >= AMT_W'(VAL_D) && cnt_d != '0 && !jam[1];
        n_ok      = rem >= AMT_W'(VAL_N) && cnt_n != '0 && !jam[0];
        sel_valid = q_ok || d_ok || n_ok;
        sel_coin  = q_ok ? QUARTER : d_ok ? DIME : NICKEL;
    end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a cent amount as quarter/dime/nickel ejects with inventory and jam tracking
module change_dispenser
    import vending_pkg::*;
#(
    parameter int AMT_W  = 9,
    parameter int CNT_W  = 8,
    parameter int Q_INIT = 20,
    parameter int D_INIT = 20,
    parameter int N_INIT = 20,
    parameter int ACK_TO = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             change_valid,
    input  logic [AMT_W-1:0] change_amt,
    output logic             change_ready,
    output logic [2:0]       coin_req,
    input  logic             coin_ack,
    input  logic             refill_valid,
    input  logic [1:0]       refill_coin,
    input  logic [CNT_W-1:0] refill_qty,
    output logic             done,
    output logic [AMT_W-1:0] shortfall,
    output logic [2:0]       jam,
    output logic [CNT_W-1:0] inv_q,
    output logic [CNT_W-1:0] inv_d,
    output logic [CNT_W-1:0] inv_n
);
    localparam int TMR_W = $clog2(ACK_TO) + 1;
    localparam logic [CNT_W-1:0] INIT [3] = '{CNT_W'(N_INIT), CNT_W'(D_INIT), CNT_W'(Q_INIT)};

    state_t           state, state_nx;
    coin_t            cur, sel_coin;
    logic             sel_valid, ack_take, timeout;
    logic [AMT_W-1:0] rem;
    logic [TMR_W-1:0] tmr;
    logic [CNT_W-1:0] inv [3];
    logic [CNT_W-1:0] inv_nx [3];
    logic [CNT_W:0]   sum [3];
    logic [2:0]       jam_nx;

    assign inv_q = inv[QUARTER];
    assign inv_d = inv[DIME];
    assign inv_n = inv[NICKEL];

    coin_select #(.AMT_W(AMT_W), .CNT_W(CNT_W)) u_sel (
        .rem      (rem),
        .cnt_q    (inv[QUARTER]),
        .cnt_d    (inv[DIME]),
        .cnt_n    (inv[NICKEL]),
        .jam      (jam),
        .sel_valid(sel_valid),
        .sel_coin (sel_coin)
    );

    always_comb begin
        state_nx     = state;
        ack_take     = state == S_EJECT && coin_ack;
        timeout      = state == S_EJECT && !coin_ack && tmr == TMR_W'(ACK_TO - 1);
        change_ready = state == S_IDLE;
        done         = state == S_DONE;
        coin_req     = state == S_EJECT ? coin_onehot(cur) : 3'b000;
        case (state)
            S_IDLE:   state_nx = change_valid ? S_SELECT : S_IDLE;
            S_SELECT: state_nx = sel_valid ? S_EJECT : S_DONE;
            S_EJECT:  state_nx = (ack_take || timeout) ? S_SELECT : S_EJECT;
            default:  state_nx = S_IDLE;
        endcase
    end

    // refill and ack may hit the same counter in one cycle; widen by one bit and saturate
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            sum[i]    = {1'b0, inv[i]}
                      + ((refill_valid && refill_coin == 2'(i)) ? {1'b0, refill_qty} : '0)
                      - ((ack_take && cur == coin_t'(i)) ? (CNT_W+1)'(1) : '0);
            inv_nx[i] = sum[i][CNT_W] ? '1 : sum[i][CNT_W-1:0];
            jam_nx[i] = (refill_valid && refill_coin == 2'(i)) ? 1'b0 :
                        (timeout && cur == coin_t'(i)) ? 1'b1 : jam[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cur       <= NICKEL;
            rem       <= '0;
            tmr       <= '0;
            shortfall <= '0;
            jam       <= '0;
            for (int i = 0; i < 3; i++) inv[i] <= INIT[i];
        end else begin
            state <= state_nx;
            jam   <= jam_nx;
            for (int i = 0; i < 3; i++) inv[i] <= inv_nx[i];
            if (state == S_IDLE && change_valid) rem <= change_amt;
            if (ack_take) rem <= rem - AMT_W'(coin_value(cur));
            if (state == S_SELECT) begin
                cur <= sel_coin;
                tmr <= '0;
            end
            if (state == S_SELECT && !sel_valid) shortfall <= rem;
            if (state == S_EJECT) tmr <= tmr + 1'b1;
        end
    end
endmodule
